data_memory_ctrl: RTL and testbench

//  Parametrised word-array data memory for the MEM stage, with MIPS sub-word access
//  (LB/LBU/LH/LHU/SB/SH/SW/LW), little-endian byte lanes and alignment checking.

---
 rtl/data_memory_ctrl.sv | 166 ++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl
// Description : MEM-stage word-array data memory with MIPS sub-word loads and
//               stores, alignment checking and optional wait-state stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              misaligned
);

    localparam int                c_idx_w    = $clog2(DEPTH);
    localparam int                c_cnt_w    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam bit                c_wait_en  = (WAIT_CYCLES != 0);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [31:0]          mem_q [DEPTH];

    logic                 w_req;
    logic                 w_mis_raw;
    logic                 w_req_ok;
    logic                 w_done;
    logic                 w_stall;
    logic                 w_we;
    logic [c_idx_w-1:0]   w_idx;
    logic [4:0]           w_lane;
    logic [31:0]          w_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;
    logic [31:0]          w_store;
    logic                 w_unused_addr;

    assign w_req    = MemRead | MemWrite;
    assign w_req_ok = w_req & ~w_mis_raw;
    assign w_idx    = address[2 +: c_idx_w];
    assign w_lane   = {address[1:0], 3'b000};
    assign w_word   = mem_q[w_idx];
    assign w_byte   = w_word[w_lane +: 8];
    assign w_half   = address[1] ? w_word[31:16] : w_word[15:0];

    // Upper address bits intentionally alias onto the word index.
    assign w_unused_addr = ^address[ADDR_W-1:c_idx_w+2];

    always_comb begin
        w_mis_raw = 1'b0;
        case (size)
            2'b00:   w_mis_raw = 1'b0;
            2'b01:   w_mis_raw = address[0];
            default: w_mis_raw = |address[1:0];
        endcase
    end

    always_comb begin
        w_load = w_word;
        case (size)
            2'b00:   w_load = {{24{sign_ext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{sign_ext & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        w_store = w_word;
        case (size)
            2'b00:   w_store[w_lane +: 8] = write_data[7:0];
            2'b01:   w_store[{address[1], 4'b0000} +: 16] = write_data[15:0];
            default: w_store = write_data;
        endcase
    end

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign w_done  = w_req_ok;
            assign w_stall = 1'b0;
        end else begin : g_wait
            assign w_done  = w_req_ok && (state_q == S_DONE);
            assign w_stall = w_req && ((state_q == S_WAIT) ||
                                       ((state_q == S_IDLE) && !w_mis_raw));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (c_wait_en && w_req_ok) begin
                    cnt_d   = c_cnt_load;
                    state_d = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                    if (cnt_q == c_cnt_one) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store commits only at the end of the completing cycle; reset drops it.
    assign w_we = w_done & MemWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_we) begin
            mem_q[w_idx] <= w_store;
        end
    end

    assign stall      = w_stall & ~reset;
    assign misaligned = w_req & w_mis_raw & ~reset;
    assign read_data  = (w_done && MemRead && !reset) ? w_load : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_ctrl
// Description : Scoreboard bench for data_memory_ctrl, zero-wait and 3-wait
//               instances driven from one directed stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic        MemRead, MemWrite, sign_ext;
    logic [1:0]  size;
    logic [31:0] address, write_data;
    logic [31:0] rd0, rd3;
    logic        st0, st3, mis0, mis3;

    data_memory_ctrl #(.DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .MemRead(MemRead), .MemWrite(MemWrite),
        .size(size), .sign_ext(sign_ext), .address(address), .write_data(write_data),
        .read_data(rd0), .stall(st0), .misaligned(mis0)
    );

    data_memory_ctrl #(.DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst3), .MemRead(MemRead), .MemWrite(MemWrite),
        .size(size), .sign_ext(sign_ext), .address(address), .write_data(write_data),
        .read_data(rd3), .stall(st3), .misaligned(mis3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          which;
        logic [31:0] rd;
        bit          st;
        bit          mis;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [1:0] c_b = 2'b00;
    localparam logic [1:0] c_h = 2'b01;
    localparam logic [1:0] c_w = 2'b10;

    // Monitor: compares every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            logic [31:0] a_rd;
            logic        a_st, a_mis;
            e     = sb.pop_front();
            a_rd  = e.which ? rd3  : rd0;
            a_st  = e.which ? st3  : st0;
            a_mis = e.which ? mis3 : mis0;
            n_total++;
            if (e.cyc == cyc && a_rd === e.rd && a_st === e.st && a_mis === e.mis) begin
                n_pass++;
            end else begin
                $display("FAIL %s cyc=%0d: got rd=%h stall=%b mis=%b, required rd=%h stall=%b mis=%b",
                         e.name, cyc, a_rd, a_st, a_mis, e.rd, e.st, e.mis);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [1:0] sz,
                         input bit sx, input logic [31:0] a, input logic [31:0] wd);
        MemRead    = rd;
        MemWrite   = wr;
        size       = sz;
        sign_ext   = sx;
        address    = a;
        write_data = wd;
    endtask

    task automatic exp_push(input string n, input bit w, input logic [31:0] r,
                            input bit s, input bit m);
        exp_t x;
        x.cyc = cyc; x.which = w; x.rd = r; x.st = s; x.mis = m; x.name = n;
        sb.push_back(x);
    endtask

    task automatic op0(input string n, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_mis);
        step();
        drive(rd, wr, sz, sx, a, wd);
        exp_push(n, 1'b0, exp_rd, 1'b0, exp_mis);
    endtask

    // One held access on the 3-wait instance: stall for 3 cycles, data in the 4th.
    task automatic acc3(input string n, input bit rd, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        for (int i = 0; i < 4; i++) begin
            step();
            drive(rd, wr, sz, 1'b0, a, wd);
            exp_push(n, 1'b1, (i == 3) ? exp_rd : 32'h0, (i < 3), 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 0, c_w, 0, 32'h0, 32'h0);

        // Zero-wait instance, starting under reset.
        op0("reset_lw",        1, 0, c_w, 0, 32'h10, 32'h0, 32'h0, 0);
        op0("reset_mis_gated", 1, 0, c_h, 1, 32'h9,  32'h0, 32'h0, 0);
        step();
        rst0 = 1'b0;
        drive(1, 0, c_w, 0, 32'h10, 32'h0);
        exp_push("lw_after_reset", 1'b0, 32'h0, 1'b0, 1'b0);

        op0("sw_8",        0, 1, c_w, 0, 32'h8, 32'h11223344, 32'h0,        0);
        op0("lw_8",        1, 0, c_w, 0, 32'h8, 32'h0,        32'h11223344, 0);
        op0("lb_9",        1, 0, c_b, 1, 32'h9, 32'h0,        32'h00000033, 0);
        op0("lh_a",        1, 0, c_h, 1, 32'hA, 32'h0,        32'h00001122, 0);
        op0("sb_b",        0, 1, c_b, 0, 32'hB, 32'h000000FF, 32'h0,        0);
        op0("lb_b",        1, 0, c_b, 1, 32'hB, 32'h0,        32'hFFFFFFFF, 0);
        op0("lbu_b",       1, 0, c_b, 0, 32'hB, 32'h0,        32'h000000FF, 0);
        op0("lw_8_sb",     1, 0, c_w, 0, 32'h8, 32'h0,        32'hFF223344, 0);
        op0("sh_8",        0, 1, c_h, 0, 32'h8, 32'h0000ABCD, 32'h0,        0);
        op0("lw_8_sh",     1, 0, c_w, 0, 32'h8, 32'h0,        32'hFF22ABCD, 0);
        op0("lh_8",        1, 0, c_h, 1, 32'h8, 32'h0,        32'hFFFFABCD, 0);
        op0("lhu_8",       1, 0, c_h, 0, 32'h8, 32'h0,        32'h0000ABCD, 0);
        op0("lb_8",        1, 0, c_b, 1, 32'h8, 32'h0,        32'hFFFFFFCD, 0);
        op0("lw_size3",    1, 0, 2'b11, 0, 32'h8, 32'h0,      32'hFF22ABCD, 0);
        op0("lh_9_mis",    1, 0, c_h, 1, 32'h9, 32'h0,        32'h0,        1);
        op0("lw_6_mis",    1, 0, c_w, 0, 32'h6, 32'h0,        32'h0,        1);
        op0("sw_3_mis",    0, 1, c_w, 0, 32'h3, 32'hDEADBEEF, 32'h0,        1);
        op0("lw_0_nowr",   1, 0, c_w, 0, 32'h0, 32'h0,        32'h0,        0);
        op0("lw_4_nowr",   1, 0, c_w, 0, 32'h4, 32'h0,        32'h0,        0);
        op0("lw_8_kept",   1, 0, c_w, 0, 32'h8, 32'h0,        32'hFF22ABCD, 0);
        op0("sw_100",      0, 1, c_w, 0, 32'h100, 32'hCAFEF00D, 32'h0,      0);
        op0("lw_0_wrap",   1, 0, c_w, 0, 32'h0, 32'h0,        32'hCAFEF00D, 0);
        op0("rw_both_10",  1, 1, c_w, 0, 32'h10, 32'h55667788, 32'h0,       0);
        op0("lw_10",       1, 0, c_w, 0, 32'h10, 32'h0,       32'h55667788, 0);
        op0("idle0",       0, 0, c_w, 0, 32'h10, 32'h0,       32'h0,        0);

        // Three-wait instance.
        step();
        rst0 = 1'b1;
        rst3 = 1'b0;
        drive(0, 0, c_w, 0, 32'h0, 32'h0);
        exp_push("idle3", 1'b1, 32'h0, 1'b0, 1'b0);

        acc3("w3_sw_8",  0, 1, c_w, 32'h8, 32'h12345678, 32'h0);
        acc3("w3_lw_8",  1, 0, c_w, 32'h8, 32'h0,        32'h12345678);

        step();
        drive(0, 1, c_w, 0, 32'h8, 32'h99999999);
        exp_push("w3_drop_c0", 1'b1, 32'h0, 1'b1, 1'b0);
        step();
        drive(0, 0, c_w, 0, 32'h8, 32'h99999999);
        exp_push("w3_drop_c1", 1'b1, 32'h0, 1'b0, 1'b0);
        acc3("w3_lw_nodrop", 1, 0, c_w, 32'h8, 32'h0, 32'h12345678);

        step();
        drive(1, 0, c_w, 0, 32'h6, 32'h0);
        exp_push("w3_lw_6_mis", 1'b1, 32'h0, 1'b0, 1'b1);

        acc3("w3_rw_both", 1, 1, c_w, 32'h8, 32'hA5A5A5A5, 32'h12345678);
        acc3("w3_lw_both", 1, 0, c_w, 32'h8, 32'h0,        32'hA5A5A5A5);

        step();
        drive(1, 0, c_w, 0, 32'h8, 32'h0);
        exp_push("w3_rst_c0", 1'b1, 32'h0, 1'b1, 1'b0);
        step();
        exp_push("w3_rst_c1", 1'b1, 32'h0, 1'b1, 1'b0);
        step();
        rst3 = 1'b1;
        exp_push("w3_rst_c2", 1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst3 = 1'b0;
        drive(0, 0, c_w, 0, 32'h8, 32'h0);
        acc3("w3_lw_cleared", 1, 0, c_w, 32'h8, 32'h0, 32'h0);

        step();
        drive(0, 0, c_w, 0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
